// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: decodes one instruction into ALU operands and holds it behind a
// valid/ready handshake. Define ALU_ISSUE_SKID_EN to add a skid entry with a registered ready.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic        flush_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [3:0]  alu_control_o,
    output logic [4:0]  rd_o,
    output logic        illegal_o
);

    localparam logic [6:0] OpReg = 7'b0110011;
    localparam logic [6:0] OpImm = 7'b0010011;
    localparam logic [6:0] OpLui = 7'b0110111;

    localparam logic [3:0] AluAdd = 4'b0000;
    localparam logic [3:0] AluSub = 4'b0001;
    localparam logic [3:0] AluSlt = 4'b0010;
    localparam logic [3:0] AluAnd = 4'b0011;
    localparam logic [3:0] AluOr  = 4'b0100;
    localparam logic [3:0] AluXor = 4'b0101;
    localparam logic [3:0] AluSll = 4'b0110;
    localparam logic [3:0] AluSrl = 4'b0111;
    localparam logic [3:0] AluSra = 4'b1000;

    localparam logic [6:0] F7Zero = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        illegal;
    } entry_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] op2;
    logic [31:0] shamt_ext;
    logic        legal;
    entry_t      dec;

    assign opcode    = instr_i[6:0];
    assign funct3    = instr_i[14:12];
    assign funct7    = instr_i[31:25];
    assign op2       = (opcode == OpReg) ? rs2_data_i : {{20{instr_i[31]}}, instr_i[31:20]};
    assign shamt_ext = {27'b0, op2[4:0]};

    always_comb begin
        dec         = '0;
        legal       = 1'b1;
        dec.rd      = instr_i[11:7];
        dec.illegal = 1'b0;
        case (opcode)
            OpReg, OpImm: begin
                if (opcode == OpReg && funct7 != F7Zero &&
                    !(funct7 == F7Alt && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    legal = 1'b0;
                end
                case (funct3)
                    3'b000: begin
                        if (opcode == OpReg && funct7 == F7Alt) begin
                            dec.a    = rs2_data_i;
                            dec.b    = rs1_data_i;
                            dec.ctrl = AluSub;
                        end else begin
                            dec.a    = rs1_data_i;
                            dec.b    = op2;
                            dec.ctrl = AluAdd;
                        end
                    end
                    3'b001: begin
                        if (opcode == OpImm && funct7 != F7Zero) legal = 1'b0;
                        dec.a    = shamt_ext;
                        dec.b    = rs1_data_i;
                        dec.ctrl = AluSll;
                    end
                    // Signed compare is mapped onto the unsigned comparator by flipping sign bits.
                    3'b010: begin
                        dec.a    = rs1_data_i ^ 32'h8000_0000;
                        dec.b    = op2 ^ 32'h8000_0000;
                        dec.ctrl = AluSlt;
                    end
                    3'b011: begin
                        dec.a    = rs1_data_i;
                        dec.b    = op2;
                        dec.ctrl = AluSlt;
                    end
                    3'b100: begin
                        dec.a    = rs1_data_i;
                        dec.b    = op2;
                        dec.ctrl = AluXor;
                    end
                    3'b101: begin
                        if (opcode == OpImm && funct7 != F7Zero && funct7 != F7Alt) begin
                            legal = 1'b0;
                        end
                        if (funct7 == F7Alt) begin
                            dec.a    = rs1_data_i;
                            dec.b    = shamt_ext;
                            dec.ctrl = AluSra;
                        end else begin
                            dec.a    = shamt_ext;
                            dec.b    = rs1_data_i;
                            dec.ctrl = AluSrl;
                        end
                    end
                    3'b110: begin
                        dec.a    = rs1_data_i;
                        dec.b    = op2;
                        dec.ctrl = AluOr;
                    end
                    default: begin
                        dec.a    = rs1_data_i;
                        dec.b    = op2;
                        dec.ctrl = AluAnd;
                    end
                endcase
            end
            OpLui: begin
                dec.a    = 32'h0;
                dec.b    = {instr_i[31:12], 12'b0};
                dec.ctrl = AluAdd;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    entry_t out_q, out_d;
    logic   out_valid_q, out_valid_d;
    logic   accept;
    logic   retire;

    assign accept = in_valid_i && in_ready_o;
    assign retire = out_valid_q && out_ready_i;

`ifdef ALU_ISSUE_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   ready_q, ready_d;

    assign in_ready_o = ready_q;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || retire) begin
            // Output slot frees up: the older skid entry always goes first.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end
`else
    assign in_ready_o = !out_valid_q || out_ready_i;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_d       = dec;
            out_valid_d = 1'b1;
        end else if (retire) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign alu_a_o       = out_q.a;
    assign alu_b_o       = out_q.b;
    assign alu_control_o = out_q.ctrl;
    assign rd_o          = out_q.rd;
    assign illegal_o     = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: queue-based reference model plus directed literal checks.
// Works with or without ALU_ISSUE_SKID_EN defined.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd;
    logic        illegal;

    alu_issue_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .instr_i       (instr),
        .rs1_data_i    (rs1),
        .rs2_data_i    (rs2),
        .flush_i       (flush),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .alu_a_o       (alu_a),
        .alu_b_o       (alu_b),
        .alu_control_o (alu_ctrl),
        .rd_o          (rd),
        .illegal_o     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] s2,
                                           input logic [4:0] s1, input logic [2:0] f3,
                                           input logic [4:0] d);
        return {f7, s2, s1, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] s1,
                                           input logic [2:0] f3, input logic [4:0] d);
        return {imm, s1, f3, d, 7'b0010011};
    endfunction

    // Reference decode written from the instruction-set rules.
    function automatic exp_t model_decode(input logic [31:0] w, input logic [31:0] r1,
                                          input logic [31:0] r2);
        exp_t        e;
        logic [6:0]  opc;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] op2;
        logic [31:0] sh;
        logic        is_r;
        logic        is_i;
        logic        bad;
        opc  = w[6:0];
        f7   = w[31:25];
        f3   = w[14:12];
        is_r = (opc == 7'b0110011);
        is_i = (opc == 7'b0010011);
        e    = '0;
        if (opc == 7'b0110111) begin
            e.b  = {w[31:12], 12'h000};
            e.rd = w[11:7];
            return e;
        end
        bad = !(is_r || is_i);
        if (is_r && !(f7 == 7'd0 || (f7 == 7'd32 && (f3 == 3'd0 || f3 == 3'd5)))) bad = 1'b1;
        if (is_i && f3 == 3'd1 && f7 != 7'd0) bad = 1'b1;
        if (is_i && f3 == 3'd5 && f7 != 7'd0 && f7 != 7'd32) bad = 1'b1;
        if (bad) begin
            e.ill = 1'b1;
            return e;
        end
        op2  = is_r ? r2 : {{20{w[31]}}, w[31:20]};
        sh   = 32'(op2[4:0]);
        e.rd = w[11:7];
        case (f3)
            3'd0: if (is_r && f7 == 7'd32) e = '{r2, r1, 4'd1, w[11:7], 1'b0};
                  else                     e = '{r1, op2, 4'd0, w[11:7], 1'b0};
            3'd1: e = '{sh, r1, 4'd6, w[11:7], 1'b0};
            3'd2: e = '{r1 ^ 32'h8000_0000, op2 ^ 32'h8000_0000, 4'd2, w[11:7], 1'b0};
            3'd3: e = '{r1, op2, 4'd2, w[11:7], 1'b0};
            3'd4: e = '{r1, op2, 4'd5, w[11:7], 1'b0};
            3'd5: if (f7 == 7'd32) e = '{r1, sh, 4'd8, w[11:7], 1'b0};
                  else             e = '{sh, r1, 4'd7, w[11:7], 1'b0};
            3'd6: e = '{r1, op2, 4'd4, w[11:7], 1'b0};
            default: e = '{r1, op2, 4'd3, w[11:7], 1'b0};
        endcase
        return e;
    endfunction

    function automatic logic model_ready(input logic ordy);
`ifdef ALU_ISSUE_SKID_EN
        return q.size() < 2;
`else
        return q.size() == 0 || ordy;
`endif
    endfunction

    // One clock: drive at negedge, compare DUT against model, then advance model across posedge.
    task automatic step(input logic v, input logic [31:0] w, input logic [31:0] r1,
                        input logic [31:0] r2, input logic fl, input logic ordy);
        logic exp_rdy;
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        instr     = w;
        rs1       = r1;
        rs2       = r2;
        flush     = fl;
        out_ready = ordy;
        #1;
        exp_rdy = model_ready(ordy);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            e = q[0];
            check("alu_a", alu_a, e.a);
            check("alu_b", alu_b, e.b);
            check("alu_control", 32'(alu_ctrl), 32'(e.ctrl));
            check("rd", 32'(rd), 32'(e.rd));
            check("illegal", 32'(illegal), 32'(e.ill));
        end
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (v && exp_rdy) q.push_back(model_decode(w, r1, r2));
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          sel;
        int          f;
        w   = $urandom();
        sel = $urandom_range(0, 9);
        f   = $urandom_range(0, 3);
        if (sel <= 3)      w[6:0] = 7'b0110011;
        else if (sel <= 7) w[6:0] = 7'b0010011;
        else if (sel == 8) w[6:0] = 7'b0110111;
        if (sel <= 7 && f <= 1) w[31:25] = 7'b0000000;
        if (sel <= 7 && f == 2) w[31:25] = 7'b0100000;
        return w;
    endfunction

    initial begin
        logic [31:0] sub_i;
        logic [31:0] add_i;
        in_valid  = 1'b0;
        instr     = '0;
        rs1       = '0;
        rs2       = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_ctrl", 32'(alu_ctrl), 32'd0);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);

        // SUB x3, x1, x2
        sub_i = r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3);
        step(1'b1, sub_i, 32'd10, 32'd3, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("sub_valid", 32'(out_valid), 32'd1);
        check("sub_a", alu_a, 32'd3);
        check("sub_b", alu_b, 32'd10);
        check("sub_ctrl", 32'(alu_ctrl), 32'd1);
        check("sub_rd", 32'(rd), 32'd3);

        // SLTI / SLTIU x5, x1, 1 with rs1 = -1
        step(1'b1, i_type(12'd1, 5'd1, 3'b010, 5'd5), 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("slti_a", alu_a, 32'h7FFF_FFFF);
        check("slti_b", alu_b, 32'h8000_0001);
        check("slti_ctrl", 32'(alu_ctrl), 32'd2);
        step(1'b1, i_type(12'd1, 5'd1, 3'b011, 5'd5), 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("sltiu_a", alu_a, 32'hFFFF_FFFF);
        check("sltiu_b", alu_b, 32'h0000_0001);

        // SRAI x7, x1, 4 and an illegal funct7 on OP
        step(1'b1, i_type({7'b0100000, 5'd4}, 5'd1, 3'b101, 5'd7), 32'h8000_0000, 32'h0,
             1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("srai_a", alu_a, 32'h8000_0000);
        check("srai_b", alu_b, 32'd4);
        check("srai_ctrl", 32'(alu_ctrl), 32'd8);
        step(1'b1, r_type(7'b0100001, 5'd2, 5'd1, 3'b000, 5'd9), 32'h1234, 32'h5678, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_a", alu_a, 32'd0);
        check("ill_b", alu_b, 32'd0);
        check("ill_ctrl", 32'(alu_ctrl), 32'd0);
        check("ill_rd", 32'(rd), 32'd0);

        // Stall with input held, then drain.
        add_i = r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd4);
        step(1'b1, add_i, 32'd1, 32'd2, 1'b0, 1'b1);
        repeat (3) step(1'b1, add_i, 32'd5, 32'd6, 1'b0, 1'b0);
        repeat (4) step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

        // Flush with a concurrent offer while an entry is held.
        step(1'b1, add_i, 32'd7, 32'd8, 1'b0, 1'b0);
        step(1'b1, add_i, 32'd9, 32'd9, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("flush_valid", 32'(out_valid), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), rand_instr(), $urandom(), $urandom(),
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 6));
        end

        // Asynchronous reset in mid-stall.
        step(1'b1, add_i, 32'd3, 32'd4, 1'b0, 1'b1);
        step(1'b1, add_i, 32'd5, 32'd6, 1'b0, 1'b0);
        step(1'b1, add_i, 32'd7, 32'd8, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_a", alu_a, 32'd0);
        check("mid_rst_b", alu_b, 32'd0);
        check("mid_rst_ctrl", 32'(alu_ctrl), 32'd0);
        check("mid_rst_rd", 32'(rd), 32'd0);
        check("mid_rst_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (20) step(($urandom_range(0, 1) == 1), rand_instr(), $urandom(), $urandom(),
                         1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK  input  1  rising-edge clock; RSTN  input  1  asynchronous active-low reset.
REQ-002 IN_VALID  input  1  decoded instruction and operands presented.
REQ-003 IN_READY  output  1  stage accepts input this cycle.
REQ-004 INSTR  input  32  RV32I instruction word.
REQ-005 RS1_DATA, RS2_DATA  input  32 each  register-file read data.
REQ-006 FLUSH  input  1  synchronous kill of all held entries.
REQ-007 OUT_VALID  output  1  ALU_A, ALU_B, ALU_CONTROL, RD and ILLEGAL are valid.
REQ-008 OUT_READY  input  1  downstream consumes the output entry this cycle.
REQ-009 ALU_A, ALU_B  output  32 each  ALU operands; ALU_CONTROL  output  4  ALU opcode; RD  output  5  destination register; ILLEGAL  output  1  unsupported encoding.

Function
REQ-010 The input is accepted when IN_VALID && IN_READY; the decoded entry SHALL appear on the outputs with OUT_VALID=1 exactly one cycle after acceptance.
REQ-011 The output entry SHALL hold stable while OUT_VALID && !OUT_READY; it SHALL retire on OUT_VALID && OUT_READY.
REQ-012 ALU codes: 0000 ADD (A+B), 0001 SUB (B-A), 0010 SLT (unsigned A<B), 0011 AND, 0100 OR, 0101 XOR, 0110 SLL (B<<A), 0111 SRL (B>>A), 1000 SRA (A>>>B).
REQ-013 op2 SHALL be RS2_DATA for opcode 0110011 and sign-extended INSTR[31:20] for opcode 0010011; shamt SHALL be op2[4:0].
REQ-014 ADD/ADDI: A=RS1, B=op2, code 0000; SUB: A=RS2, B=RS1, code 0001.
REQ-015 SLT/SLTI: A=RS1^32'h80000000, B=op2^32'h80000000, code 0010; SLTU/SLTIU: A=RS1, B=op2, code 0010.
REQ-016 AND/OR/XOR(I): A=RS1, B=op2, codes 0011/0100/0101.
REQ-017 SLL(I)/SRL(I): A={27'b0,shamt}, B=RS1, codes 0110/0111; SRA(I): A=RS1, B={27'b0,shamt}, code 1000.
REQ-018 LUI (0110111): A=0, B={INSTR[31:12],12'b0}, code 0000.
REQ-019 RD SHALL equal INSTR[11:7] for all legal encodings.
REQ-020 Illegal: any other opcode; funct7 other than 0000000 for opcode 0110011, except 0100000 with funct3 000 or 101; slli/srli with INSTR[31:25]!=0; srai with INSTR[31:25]!=0100000. Illegal entries SHALL carry ILLEGAL=1, ALU_A=ALU_B=0, ALU_CONTROL=0000, RD=0, and follow the normal handshake.
REQ-021 FLUSH=1 SHALL clear every held entry (OUT_VALID=0 next cycle) and SHALL drop any input offered in the same cycle; FLUSH has priority over accept and retire.
REQ-022 Simultaneous retire and accept in the same cycle SHALL replace the entry without a bubble.

Reset
REQ-023 RSTN=0 SHALL asynchronously force OUT_VALID=0, ALU_A=0, ALU_B=0, ALU_CONTROL=0000, RD=0, ILLEGAL=0, and empty all internal entries.
REQ-024 IN_READY SHALL be 1 in the first cycle after RSTN deasserts; reset in mid-stall SHALL discard the held entry.

Configuration
REQ-025 Macro ALU_ISSUE_SKID_EN. Undefined: single entry; IN_READY = !OUT_VALID || OUT_READY (combinational path from OUT_READY).
REQ-026 Defined: a second skid entry is added; IN_READY SHALL be a register output equal to "skid entry empty"; an input accepted while the output entry is stalled SHALL go to the skid entry and move to the output entry on the next retire; order SHALL be preserved; FLUSH clears both entries.

Verification
REQ-027 SUB x3,x1,x2 with RS1=10, RS2=3 -> next cycle OUT_VALID=1, ALU_A=3, ALU_B=10, ALU_CONTROL=0001, RD=3.
REQ-028 SLTI with RS1=32'hFFFFFFFF, imm=1 -> ALU_A=32'h7FFFFFFF, ALU_B=32'h80000001, ALU_CONTROL=0010; SLTIU with the same operands -> ALU_A=32'hFFFFFFFF, ALU_B=1.
REQ-029 SRAI shamt=4 with RS1=32'h80000000 -> ALU_A=32'h80000000, ALU_B=4, code 1000; funct7=0100001 on opcode 0110011 -> ILLEGAL=1, all other outputs 0.
REQ-030 OUT_READY=0 for 3 cycles with IN_VALID held -> outputs stable, IN_READY=0 (skid disabled) or IN_READY falls one cycle after a second accept (skid enabled); no entry lost or duplicated.
REQ-031 FLUSH=1 together with IN_VALID=1 while OUT_VALID=1 -> OUT_VALID=0 next cycle, offered input not issued.
REQ-032 RSTN pulled low while stalled -> outputs 0 immediately, without a clock edge; after release IN_READY=1.
